// File: rtl/neureka_infeat_stream_tx_if.sv
// -----------------------------------------------------------------------------
// neureka_infeat_stream_tx_if
// Purpose : valid/ready word stream from the input-feature transmitter toward
//           the input-feature buffer load port.
// Signals : feat_valid  word valid (driven by the transmitter)
//           feat_ready  sink ready (driven by the buffer)
//           feat_data   DS-bit stream word
//           feat_strb   byte strobe, all ones while feat_valid is high
//           feat_last   last word of the burst (only with NEUREKA_INFEAT_TX_LAST_EN)
// Modports: master = transmitter side, slave = buffer side.
// Config  : NEUREKA_INFEAT_TX_LAST_EN adds feat_last.
// -----------------------------------------------------------------------------
interface neureka_infeat_stream_tx_if #(
    parameter int DS = 256
);
    logic            feat_valid;
    logic            feat_ready;
    logic [DS-1:0]   feat_data;
    logic [DS/8-1:0] feat_strb;
`ifdef NEUREKA_INFEAT_TX_LAST_EN
    logic            feat_last;
`endif

    modport master (
`ifdef NEUREKA_INFEAT_TX_LAST_EN
        output feat_last,
`endif
        output feat_valid,
        output feat_data,
        output feat_strb,
        input  feat_ready
    );

    modport slave (
`ifdef NEUREKA_INFEAT_TX_LAST_EN
        input  feat_last,
`endif
        input  feat_valid,
        input  feat_data,
        input  feat_strb,
        output feat_ready
    );
endinterface

// File: rtl/neureka_infeat_stream_tx.sv
// -----------------------------------------------------------------------------
// neureka_infeat_stream_tx
// Purpose : captures a full NW x DS-bit input-feature tile in one cycle and
//           serializes it as a valid/ready word stream. Per-word implicit
//           (zero) and explicit (pad value) padding are applied on the way
//           out, and 1x1 mode skips the trailing BUF_W-PE_W words of each
//           spatial row.
// Ports   : clk_i, rst_ni       clock, asynchronous active-low reset
//           clear_i             synchronous soft clear (beats enable/start)
//           enable_i            global enable, low freezes all state
//           start_i, len_i      start pulse (IDLE only) and burst length 0..NW
//           mode_1x1_i          1x1 skip addressing
//           zero_mask_i         per-word implicit padding (word forced to 0)
//           pad_mask_i          per-word explicit padding (word = pad_value_i)
//           pad_value_i         padding byte, replicated across the word
//           tile_i              parallel tile, word k = tile_i[k*DS +: DS]
//           feat                stream master (valid/ready/data/strb[/last])
//           busy_o, done_o      busy in STREAM/DONE, one-cycle done pulse
//           state_o             IDLE=0, STREAM=1, DONE=2
// Config  : define NEUREKA_INFEAT_TX_LAST_EN to drive feat.feat_last
//           (high with the final word of a burst).
// -----------------------------------------------------------------------------
module neureka_infeat_stream_tx #(
    parameter int BLOCK_SIZE = 32,
    parameter int DW         = 8,
    parameter int BUF_W      = 4,
    parameter int PE_W       = 3,
    parameter int NW         = BUF_W * BUF_W,
    parameter int AW         = $clog2(NW),
    parameter int DS         = DW * BLOCK_SIZE
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  clear_i,
    input  logic                  enable_i,
    input  logic                  start_i,
    input  logic [AW:0]           len_i,
    input  logic                  mode_1x1_i,
    input  logic [NW-1:0]         zero_mask_i,
    input  logic [NW-1:0]         pad_mask_i,
    input  logic [DW-1:0]         pad_value_i,
    input  logic [NW*DS-1:0]      tile_i,
    neureka_infeat_stream_tx_if.master feat,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [1:0]            state_o
);

    // -------------------------------------------------------------------------
    // State encoding
    // -------------------------------------------------------------------------
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // Address-step constants, sized to the address arithmetic.
    localparam logic [AW-1:0] L_BUF_W   = AW'(BUF_W);
    localparam logic [AW-1:0] L_PE_LAST = AW'(PE_W - 1);
    localparam logic [AW:0]   L_SKIP    = (AW+1)'(BUF_W - PE_W + 1);
    localparam logic [AW:0]   L_ONE     = (AW+1)'(1);
    localparam logic [AW:0]   L_NW      = (AW+1)'(NW);

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [1:0]     r_state;
    logic [AW:0]    r_cnt;
    logic [AW-1:0]  r_addr;
    logic [AW:0]    r_len;
    logic           r_mode_1x1;
    logic [NW-1:0]  r_zero_mask;
    logic [NW-1:0]  r_pad_mask;
    logic [DW-1:0]  r_pad_value;
    logic [DS-1:0]  r_tile [NW];

    // -------------------------------------------------------------------------
    // Wires
    // -------------------------------------------------------------------------
    logic           w_streaming;
    logic           w_valid;
    logic           w_xfer;
    logic           w_last_word;
    logic           w_capture;
    logic [AW-1:0]  w_addr_col;
    logic           w_row_end;
    logic [AW:0]    w_addr_step;
    logic [AW:0]    w_addr_sum;
    logic [AW-1:0]  w_addr_next;
    logic [DS-1:0]  w_word [NW];
    logic [DS-1:0]  w_word_sel;
    logic [DS-1:0]  w_pad_word;

    assign w_streaming = (r_state == ST_STREAM);
    assign w_valid     = w_streaming & enable_i;
    assign w_xfer      = w_valid & feat.feat_ready;
    assign w_last_word = (r_cnt == (r_len - L_ONE));

    // Capture happens only for a non-empty burst; an empty one leaves the
    // tile and mask registers untouched.
    assign w_capture   = enable_i & ~clear_i & (r_state == ST_IDLE) &
                         start_i & (len_i != '0);

    // -------------------------------------------------------------------------
    // Next read address. In 1x1 mode the last emitted column of each row
    // (column PE_W-1) jumps past the unused BUF_W-PE_W columns to the start
    // of the next row. The sum is one bit wider so the wrap back into 0..NW-1
    // stays correct even if NW is not a power of two.
    // -------------------------------------------------------------------------
    assign w_addr_col  = r_addr % L_BUF_W;
    assign w_row_end   = r_mode_1x1 & (w_addr_col == L_PE_LAST);
    assign w_addr_step = w_row_end ? L_SKIP : L_ONE;
    assign w_addr_sum  = {1'b0, r_addr} + w_addr_step;
    assign w_addr_next = (w_addr_sum >= L_NW) ? AW'(w_addr_sum - L_NW)
                                              : w_addr_sum[AW-1:0];

    // -------------------------------------------------------------------------
    // Tile capture: one register bank per word, loaded in parallel on start.
    // -------------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NW; gi++) begin : g_tile
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_tile[gi] <= '0;
                end else if (clear_i) begin
                    r_tile[gi] <= '0;
                end else if (w_capture) begin
                    r_tile[gi] <= tile_i[gi*DS +: DS];
                end
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Padding is resolved per word before the address mux, so the mux itself
    // only selects among final words. Zero padding outranks explicit padding.
    // -------------------------------------------------------------------------
    assign w_pad_word = {BLOCK_SIZE{r_pad_value}};

    generate
        for (genvar gi = 0; gi < NW; gi++) begin : g_word
            assign w_word[gi] = r_zero_mask[gi] ? '0         :
                                r_pad_mask[gi]  ? w_pad_word :
                                                  r_tile[gi];
        end
    endgenerate

    assign w_word_sel = w_word[r_addr];

    // -------------------------------------------------------------------------
    // Control FSM, counters and captured configuration.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_len       <= '0;
            r_mode_1x1  <= 1'b0;
            r_zero_mask <= '0;
            r_pad_mask  <= '0;
            r_pad_value <= '0;
        end else if (clear_i) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_addr      <= '0;
            r_len       <= '0;
            r_mode_1x1  <= 1'b0;
            r_zero_mask <= '0;
            r_pad_mask  <= '0;
            r_pad_value <= '0;
        end else if (enable_i) begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        if (len_i != '0) begin
                            r_state     <= ST_STREAM;
                            r_cnt       <= '0;
                            r_addr      <= '0;
                            r_len       <= len_i;
                            r_mode_1x1  <= mode_1x1_i;
                            r_zero_mask <= zero_mask_i;
                            r_pad_mask  <= pad_mask_i;
                            r_pad_value <= pad_value_i;
                        end else begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_STREAM: begin
                    if (w_xfer) begin
                        r_cnt  <= r_cnt + L_ONE;
                        r_addr <= w_addr_next;
                        if (w_last_word) begin
                            r_state <= ST_DONE;
                        end
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // Outputs. Data is forced to zero outside STREAM so the bus is quiet
    // while idle or after reset.
    // -------------------------------------------------------------------------
    assign feat.feat_valid = w_valid;
    assign feat.feat_data  = w_streaming ? w_word_sel : '0;
    assign feat.feat_strb  = {(DS/8){w_valid}};
`ifdef NEUREKA_INFEAT_TX_LAST_EN
    assign feat.feat_last  = w_valid & w_last_word;
`endif

    assign busy_o  = (r_state == ST_STREAM) | (r_state == ST_DONE);
    // done_o is qualified by enable so it is high for exactly one enabled cycle.
    assign done_o  = (r_state == ST_DONE) & enable_i;
    assign state_o = r_state;

endmodule

// File: tb/tb_neureka_infeat_stream_tx.sv
module tb_neureka_infeat_stream_tx;

    localparam int NW = 16;
    localparam int AW = 4;
    localparam int DS = 256;

    logic clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    logic              rst_ni;
    logic              clear_i;
    logic              enable_i;
    logic              start_i;
    logic [AW:0]       len_i;
    logic              mode_1x1_i;
    logic [NW-1:0]     zero_mask_i;
    logic [NW-1:0]     pad_mask_i;
    logic [7:0]        pad_value_i;
    logic [NW*DS-1:0]  tile_i;
    logic              busy_o;
    logic              done_o;
    logic [1:0]        state_o;

    neureka_infeat_stream_tx_if #(.DS(DS)) feat_if ();

    logic ready_man;
    logic ready_bp;
    logic bp_mode;
    assign feat_if.feat_ready = bp_mode ? ready_bp : ready_man;

    neureka_infeat_stream_tx dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .enable_i    (enable_i),
        .start_i     (start_i),
        .len_i       (len_i),
        .mode_1x1_i  (mode_1x1_i),
        .zero_mask_i (zero_mask_i),
        .pad_mask_i  (pad_mask_i),
        .pad_value_i (pad_value_i),
        .tile_i      (tile_i),
        .feat        (feat_if),
        .busy_o      (busy_o),
        .done_o      (done_o),
        .state_o     (state_o)
    );

    // ---------------- scoreboard state ----------------
    typedef struct {
        logic [DS-1:0] data;
        logic          last;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc_cnt = 0;
    int   xfer_cnt = 0;
    int   valid_cnt = 0;
    int   done_cnt = 0;
    int   last_xfer_cyc = 0;
    int   done_cyc = 0;
    int   skip_addr[9] = '{0, 1, 2, 4, 5, 6, 8, 9, 10};

    task automatic chk(input string name, input logic [DS-1:0] act, input logic [DS-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- backpressure ready generator (1,0,0,1 repeating) ----------------
    logic [3:0] bp_pat = 4'b1001;
    int bp_idx = 0;
    always @(posedge clk_i) begin
        #1;
        ready_bp = bp_pat[bp_idx];
        bp_idx = (bp_idx + 1) % 4;
    end

    // ---------------- monitor ----------------
    logic          prev_stall = 1'b0;
    logic [DS-1:0] prev_data  = '0;
    always @(negedge clk_i) begin
        exp_t e;
        cyc_cnt++;
        if (rst_ni) begin
            chk("strb", {224'd0, feat_if.feat_strb}, feat_if.feat_valid ? {224'd0, 32'hFFFF_FFFF} : '0);
            if (!enable_i) chk("valid_when_disabled", {255'd0, feat_if.feat_valid}, '0);
            if (prev_stall && enable_i) begin
                chk("stall_valid_hold", {255'd0, feat_if.feat_valid}, {255'd0, 1'b1});
                chk("stall_data_hold", feat_if.feat_data, prev_data);
            end
            if (feat_if.feat_valid) valid_cnt++;
            if (feat_if.feat_valid && feat_if.feat_ready) begin
                xfer_cnt++;
                last_xfer_cyc = cyc_cnt;
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_word: got %0h expected no transfer", feat_if.feat_data);
                end else begin
                    checks--;
                    e = exp_q.pop_front();
                    chk("word_data", feat_if.feat_data, e.data);
`ifdef NEUREKA_INFEAT_TX_LAST_EN
                    chk("word_last", {255'd0, feat_if.feat_last}, {255'd0, e.last});
`endif
                end
            end
`ifdef NEUREKA_INFEAT_TX_LAST_EN
            else if (feat_if.feat_last) begin
                chk("last_without_xfer_valid", {255'd0, feat_if.feat_valid}, {255'd0, 1'b1});
            end
`endif
            if (done_o) begin
                done_cnt++;
                done_cyc = cyc_cnt;
            end
            prev_stall = feat_if.feat_valid && !feat_if.feat_ready && enable_i && !clear_i;
            prev_data  = feat_if.feat_data;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set_tile(input logic [7:0] salt);
        logic [7:0] b;
        for (int k = 0; k < NW; k++) begin
            b = 8'(k) ^ salt;
            tile_i[k*DS +: DS] = {32{b}};
        end
    endtask

    function automatic logic [DS-1:0] exp_word(input int a, input logic [NW-1:0] zm,
                                                input logic [NW-1:0] pm, input logic [7:0] pv,
                                                input logic [7:0] salt);
        logic [7:0] b;
        b = 8'(a) ^ salt;
        if (zm[a]) return '0;
        if (pm[a]) return {32{pv}};
        return {32{b}};
    endfunction

    task automatic push_burst(input int len, input bit skip, input logic [NW-1:0] zm,
                              input logic [NW-1:0] pm, input logic [7:0] pv, input logic [7:0] salt);
        exp_t e;
        int a;
        for (int i = 0; i < len; i++) begin
            a = skip ? skip_addr[i] : i;
            e.data = exp_word(a, zm, pm, pv, salt);
            e.last = (i == len - 1);
            exp_q.push_back(e);
        end
    endtask

    // Pulse start for one cycle, then scramble inputs to show they were captured.
    task automatic do_start(input int len);
        len_i   = (AW+1)'(len);
        start_i = 1'b1;
        @(posedge clk_i);
        #1;
        start_i     = 1'b0;
        tile_i      = ~tile_i;
        zero_mask_i = ~zero_mask_i;
        pad_mask_i  = ~pad_mask_i;
        pad_value_i = ~pad_value_i;
        mode_1x1_i  = ~mode_1x1_i;
    endtask

    task automatic wait_done(input string name, input int exp_cyc);
        int n;
        bit seen;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 300) begin
            @(negedge clk_i);
            n++;
            if (done_o) seen = 1'b1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_timeout: got no done_o in %0d cycles expected done_o", name, n);
        end else if (exp_cyc > 0) begin
            chk({name, "_done_latency"}, DS'(n), DS'(exp_cyc));
        end
        @(negedge clk_i);
        chk({name, "_state_idle"}, {254'd0, state_o}, '0);
        chk({name, "_busy_low"}, {255'd0, busy_o}, '0);
        chk({name, "_done_single"}, {255'd0, done_o}, '0);
    endtask

    task automatic end_checks(input string name, input int len, input int x0, input int d0, input int v0);
        chk({name, "_xfers"}, DS'(xfer_cnt - x0), DS'(len));
        chk({name, "_done_count"}, DS'(done_cnt - d0), DS'(1));
        chk({name, "_queue_empty"}, DS'(exp_q.size()), '0);
        if (len > 0) chk({name, "_done_after_last"}, DS'(done_cyc), DS'(last_xfer_cyc + 1));
        else         chk({name, "_no_valid"}, DS'(valid_cnt - v0), '0);
    endtask

    task automatic run_burst(input string name, input int len, input bit skip,
                             input logic [NW-1:0] zm, input logic [NW-1:0] pm,
                             input logic [7:0] pv, input logic [7:0] salt,
                             input int en_off, input int exp_cyc);
        int x0, d0, v0;
        x0 = xfer_cnt; d0 = done_cnt; v0 = valid_cnt;
        mode_1x1_i  = skip;
        zero_mask_i = zm;
        pad_mask_i  = pm;
        pad_value_i = pv;
        set_tile(salt);
        push_burst(len, skip, zm, pm, pv, salt);
        do_start(len);
        if (en_off > 0) begin
            enable_i = 1'b0;
            repeat (en_off) @(posedge clk_i);
            #1;
            enable_i = 1'b1;
        end
        wait_done(name, exp_cyc);
        end_checks(name, len, x0, d0, v0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int x0, d0, v0;
        rst_ni = 1'b0; clear_i = 1'b0; enable_i = 1'b1; start_i = 1'b0;
        len_i = '0; mode_1x1_i = 1'b0; zero_mask_i = '0; pad_mask_i = '0;
        pad_value_i = '0; tile_i = '0; ready_man = 1'b1; bp_mode = 1'b0;

        repeat (2) @(negedge clk_i);
        chk("reset_valid", {255'd0, feat_if.feat_valid}, '0);
        chk("reset_data", feat_if.feat_data, '0);
        chk("reset_strb", {224'd0, feat_if.feat_strb}, '0);
        chk("reset_busy", {255'd0, busy_o}, '0);
        chk("reset_done", {255'd0, done_o}, '0);
        chk("reset_state", {254'd0, state_o}, '0);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        @(posedge clk_i); #1;

        run_burst("normal16", 16, 1'b0, 16'h0000, 16'h0000, 8'h00, 8'h00, 0, 17);
        run_burst("skip1x1",   9, 1'b1, 16'h0000, 16'h0000, 8'h00, 8'h00, 0, 10);
        run_burst("padding",   4, 1'b0, 16'h0003, 16'h0006, 8'hA5, 8'h30, 0, 5);
        run_burst("len0",      0, 1'b0, 16'h0000, 16'h0000, 8'h00, 8'h00, 0, 1);
        run_burst("enable_freeze", 3, 1'b0, 16'h0000, 16'h0000, 8'h00, 8'h77, 3, -1);

        bp_mode = 1'b1;
        run_burst("backpressure", 4, 1'b0, 16'h0000, 16'h0000, 8'h00, 8'hC3, 0, -1);
        bp_mode = 1'b0;

        // start while streaming must be ignored
        x0 = xfer_cnt; d0 = done_cnt; v0 = valid_cnt;
        mode_1x1_i = 1'b0; zero_mask_i = '0; pad_mask_i = '0; pad_value_i = '0;
        set_tile(8'h11);
        push_burst(4, 1'b0, '0, '0, 8'h00, 8'h11);
        do_start(4);
        do_start(16);
        wait_done("restart_ignored", -1);
        end_checks("restart_ignored", 4, x0, d0, v0);

        // abort with clear_i once 5 words have been transferred
        x0 = xfer_cnt; d0 = done_cnt;
        mode_1x1_i = 1'b0; zero_mask_i = '0; pad_mask_i = '0; pad_value_i = '0;
        set_tile(8'h00);
        push_burst(16, 1'b0, '0, '0, 8'h00, 8'h00);
        do_start(16);
        repeat (5) @(posedge clk_i);
        #1;
        clear_i = 1'b1; ready_man = 1'b0;
        @(posedge clk_i); #1;
        clear_i = 1'b0; ready_man = 1'b1;
        @(negedge clk_i);
        chk("abort_valid", {255'd0, feat_if.feat_valid}, '0);
        chk("abort_state", {254'd0, state_o}, '0);
        chk("abort_busy", {255'd0, busy_o}, '0);
        repeat (3) @(negedge clk_i);
        chk("abort_no_done", DS'(done_cnt - d0), '0);
        chk("abort_xfers", DS'(xfer_cnt - x0), DS'(5));
        exp_q.delete();
        @(posedge clk_i); #1;
        run_burst("after_abort", 2, 1'b0, 16'h0000, 16'h0000, 8'h00, 8'h5A, 0, 3);

        repeat (2) @(posedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
